// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg : shared constants and types for the 4-digit scan driver     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int NUM_DIGITS          = 4;
  localparam int DEFAULT_REFRESH_DIV = 100000;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

  function automatic logic [3:0] nibble_at(input logic [15:0] value, input digit_idx_t idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_refresh_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_refresh_prescaler : free-running 0..DIV-1 counter, terminal flag |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_refresh_prescaler
  import seg_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  assign terminal = (count == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (terminal) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_driver : 4-digit multiplexed display scanner, frame-synced  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV   = DEFAULT_REFRESH_DIV,
  parameter int BLANK_LEADING = 1
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [15:0] VALUE_IN,
  input  logic [3:0]  DOT_MASK_IN,
  input  logic        LOAD_IN,
  output logic        LOAD_ACK,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic        BLANK_OUT,
  output logic        DIGIT_STROBE
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] presc_count;
  logic          terminal;
  logic          unused_presc;
  digit_idx_t    index;
  logic [15:0]   disp_value;
  logic [3:0]    disp_mask;
  logic [15:0]   pend_value;
  logic [3:0]    pend_mask;
  logic          pend_flag;
  logic          frame_boundary;
  logic          upper_zero;

  seg_refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk      (CLK),
    .rst_n    (RESETN),
    .count    (presc_count),
    .terminal (terminal)
  );

  assign unused_presc   = ^presc_count;
  assign frame_boundary = terminal && (index == digit_idx_t'(NUM_DIGITS - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      index        <= '0;
      DIGIT_STROBE <= 1'b0;
    end else begin
      DIGIT_STROBE <= terminal;
      if (terminal) begin
        index <= index + 1'b1;
      end
    end
  end

  // Display data only changes on the frame boundary so a frame never mixes old and new digits.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      disp_value <= '0;
      disp_mask  <= '0;
      pend_value <= '0;
      pend_mask  <= '0;
      pend_flag  <= 1'b0;
      LOAD_ACK   <= 1'b0;
    end else begin
      LOAD_ACK <= 1'b0;
      if (frame_boundary) begin
        if (LOAD_IN) begin
          disp_value <= VALUE_IN;
          disp_mask  <= DOT_MASK_IN;
          pend_flag  <= 1'b0;
          LOAD_ACK   <= 1'b1;
        end else if (pend_flag) begin
          disp_value <= pend_value;
          disp_mask  <= pend_mask;
          pend_flag  <= 1'b0;
          LOAD_ACK   <= 1'b1;
        end
      end else if (LOAD_IN) begin
        pend_value <= VALUE_IN;
        pend_mask  <= DOT_MASK_IN;
        pend_flag  <= 1'b1;
      end
    end
  end

  always_comb begin
    upper_zero = 1'b0;
    case (index)
      2'd1:    upper_zero = (disp_value[15:4]  == 12'h000);
      2'd2:    upper_zero = (disp_value[15:8]  == 8'h00);
      2'd3:    upper_zero = (disp_value[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign SEG_SELECT_OUT = index;
  assign BIN_OUT        = nibble_at(disp_value, index);
  assign DOT_OUT        = ~disp_mask[index];
  assign BLANK_OUT      = (BLANK_LEADING != 0) && upper_zero;

endmodule
`default_nettype wire
